// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Results are computed at issue, held while busy, and committed to HI/LO on the last busy cycle.
module mdu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operandA,
  input  logic [DATA_WIDTH-1:0] operandB,
  output logic                  busy,
  output logic                  stallRequest,
  output logic [DATA_WIDTH-1:0] readResult,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W          = DATA_WIDTH;
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [2*W-1:0]   result_reg, result_next;
  logic [W-1:0]     hi_reg, hi_next;
  logic [W-1:0]     lo_reg, lo_next;

  logic [2*W-1:0]   mul_ext_a, mul_ext_b, mul_result;
  logic             div_signed, neg_a, neg_b;
  logic [W-1:0]     mag_a, mag_b, div_den, q_mag, r_mag, quot, rem;
  logic [2*W-1:0]   div_result;

  // Multiply: sign/zero-extend to full width so the low 2W bits are the exact product.
  always_comb begin
    mul_ext_a  = (op == OP_MULT) ? {{W{operandA[W-1]}}, operandA} : {{W{1'b0}}, operandA};
    mul_ext_b  = (op == OP_MULT) ? {{W{operandB[W-1]}}, operandB} : {{W{1'b0}}, operandB};
    mul_result = mul_ext_a * mul_ext_b;
  end

  // Signed divide via magnitudes; most-negative / -1 falls out naturally as most-negative, rem 0.
  always_comb begin
    div_signed = (op == OP_DIV);
    neg_a      = div_signed & operandA[W-1];
    neg_b      = div_signed & operandB[W-1];
    mag_a      = neg_a ? -operandA : operandA;
    mag_b      = neg_b ? -operandB : operandB;
    div_den    = (mag_b == '0) ? ONE : mag_b;
    q_mag      = mag_a / div_den;
    r_mag      = mag_a % div_den;
    quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem        = neg_a ? -r_mag : r_mag;
    if (operandB == '0) begin
      quot = '1;
      rem  = operandA;
    end
    div_result = {rem, quot};
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    result_next  = result_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              result_next  = mul_result;
              counter_next = CNT_W'(MUL_CYCLES);
              state_next   = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              result_next  = div_result;
              counter_next = CNT_W'(DIV_CYCLES);
              state_next   = BUSY;
            end
            OP_MTHI: hi_next = operandA;
            OP_MTLO: lo_next = operandA;
            default: ;
          endcase
        end
      end
      default: begin
        // Any incoming start is stalled here; only the countdown advances.
        if (counter_reg <= CNT_W'(1)) begin
          hi_next      = result_reg[2*W-1:W];
          lo_next      = result_reg[W-1:0];
          counter_next = '0;
          state_next   = IDLE;
        end else begin
          counter_next = counter_reg - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      result_reg  <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      result_reg  <= result_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  assign busy         = (state_reg == BUSY);
  assign stallRequest = start && (state_reg == BUSY);
  assign hi           = hi_reg;
  assign lo           = lo_reg;

  always_comb begin
    readResult = '0;
    if (start && (state_reg == IDLE)) begin
      if (op == OP_MFHI)      readResult = hi_reg;
      else if (op == OP_MFLO) readResult = lo_reg;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: multiply/divide latency and results, moves, stalls, reset abort.
module tb_mdu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operandA, operandB;
  logic        busy, stallRequest;
  logic [31:0] readResult, hi, lo;

  int check_count = 0;
  int error_count = 0;
  logic [31:0] m_hi, m_lo;

  mdu_sequencer #(.DATA_WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .busy(busy), .stallRequest(stallRequest), .readResult(readResult),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue a MUL/DIV, verify busy for exactly n cycles with HI/LO held, then the committed result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el);
    start = 1'b1; op = o; operandA = a; operandB = b;
    #1;
    check({tag, "_stall_idle"}, stallRequest, 1'b0);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_hi_held"}, hi, m_hi);
      step();
    end
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
    $display("op %s a=%h b=%h -> hi=%h lo=%h", tag, a, b, hi, lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 3'd4; operandA = 32'hdead; operandB = '0;
    step();
    step();
    check("reset_hi_during", hi, 32'h0);
    reset = 1'b0; start = 1'b0;
    #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_stall", stallRequest, 1'b0);
    check("reset_read", readResult, 32'h0);
    m_hi = 32'h0; m_lo = 32'h0;
    $display("op reset -> hi=%h lo=%h", hi, lo);
    step();

    run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_by0", 3'd3, 32'd7, 32'd0, 10, 32'd7, 32'hFFFFFFFF);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'd1, 32'h7FFFFFFC);

    // MULTU then stalled MTLO, switching to MFLO while still busy.
    start = 1'b1; op = 3'd1; operandA = 32'hFFFFFFFF; operandB = 32'd2;
    step();
    for (int i = 0; i < 5; i++) begin
      op = (i < 2) ? 3'd5 : 3'd7;
      operandA = 32'h0000AAAA;
      #1;
      check("multu_stall", stallRequest, 1'b1);
      check("multu_lo_held", lo, m_lo);
      step();
    end
    #1;
    check("multu_stall_clear", stallRequest, 1'b0);
    check("multu_mflo", readResult, 32'hFFFFFFFE);
    check("multu_hi", hi, 32'h1);
    m_hi = 32'h1; m_lo = 32'hFFFFFFFE;
    $display("op multu+mflo -> read=%h hi=%h", readResult, hi);
    step();
    start = 1'b0;

    // MTHI then MFHI next cycle.
    start = 1'b1; op = 3'd4; operandA = 32'h1234;
    step();
    check("mthi_busy", busy, 1'b0);
    op = 3'd6; operandA = 32'h0;
    #1;
    check("mfhi_read", readResult, 32'h1234);
    check("mthi_lo_kept", lo, m_lo);
    m_hi = 32'h1234;
    $display("op mthi+mfhi -> read=%h", readResult);
    step();

    op = 3'd5; operandA = 32'h55;
    step();
    start = 1'b0;
    check("mtlo_lo", lo, 32'h55);
    check("mtlo_hi_kept", hi, m_hi);
    m_lo = 32'h55;
    $display("op mtlo -> lo=%h", lo);

    // start low: op and operands ignored.
    op = 3'd4; operandA = 32'hBEEF;
    step();
    check("nostart_hi", hi, m_hi);
    check("nostart_busy", busy, 1'b0);
    $display("op idle -> hi=%h", hi);

    // Reset during the third busy cycle aborts the divide.
    start = 1'b1; op = 3'd2; operandA = 32'd100; operandB = 32'd7;
    step();
    start = 1'b0;
    step();
    step();
    check("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) step();
    check("abort_hi_late", hi, 32'h0);
    check("abort_lo_late", lo, 32'h0);
    $display("op div+reset -> hi=%h lo=%h", hi, lo);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_WIDTH SHALL exist: default 32, operand/HI/LO width.
REQ-003 Parameter MUL_CYCLES SHALL exist: default 5, busy cycles for MULT/MULTU, legal range 1..64.
REQ-004 Parameter DIV_CYCLES SHALL exist: default 10, busy cycles for DIV/DIVU, legal range 1..64.
REQ-005 Port clock: input, 1, rising-edge clock.
REQ-006 Port reset: input, 1, synchronous active-high reset.
REQ-007 Port start: input, 1, operation valid this cycle.
REQ-008 Port op: input, 3, 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-009 Port operandA: input, DATA_WIDTH, rs value (multiplicand/dividend/MT source).
REQ-010 Port operandB: input, DATA_WIDTH, rt value (multiplier/divisor).
REQ-011 Port busy: output, 1, high while a MUL/DIV is in flight.
REQ-012 Port stallRequest: output, 1, combinational; high when start is high and the op cannot be accepted this cycle.
REQ-013 Port readResult: output, DATA_WIDTH, combinational HI (MFHI) or LO (MFLO), else 0.
REQ-014 Port hi, lo: output, DATA_WIDTH each, architectural HI/LO registers.

Function
REQ-015 The block SHALL implement states IDLE and BUSY; reset SHALL force IDLE.
REQ-016 In IDLE, start with op MULT/MULTU/DIV/DIVU SHALL latch the full 2*DATA_WIDTH result, load counter with MUL_CYCLES or DIV_CYCLES, and enter BUSY at the next edge.
REQ-017 In BUSY, the counter SHALL decrement each cycle; when it reaches 1, the next edge SHALL write the latched result into HI/LO and return to IDLE.
REQ-018 Latency: with start accepted at edge T, hi/lo SHALL show the new result after edge T+N (N = op cycle count); busy SHALL be high for exactly N cycles after edge T.
REQ-019 MULT SHALL be a signed DATA_WIDTH x DATA_WIDTH product; MULTU unsigned; HI = upper half, LO = lower half.
REQ-020 DIV/DIVU SHALL give LO = quotient truncated toward zero, HI = remainder with dividend sign (DIV) or unsigned (DIVU).
REQ-021 Divisor 0 SHALL give LO = all ones, HI = operandA, for both DIV and DIVU.
REQ-022 DIV of most-negative value by -1 SHALL give LO = most-negative value, HI = 0.
REQ-023 MTHI/MTLO in IDLE SHALL write operandA into HI/LO at the next edge; the other register SHALL be unchanged.
REQ-024 MFHI/MFLO in IDLE SHALL drive readResult combinationally from the current hi/lo; no state change.
REQ-025 Any start (all eight ops) while BUSY SHALL assert stallRequest, SHALL not be accepted, and SHALL not alter HI/LO or counter.
REQ-026 On the final BUSY cycle (counter = 1), stallRequest SHALL still be asserted; the stalled op SHALL be accepted in the following IDLE cycle and SHALL see the new HI/LO.
REQ-027 start low SHALL cause no state change; op and operands SHALL then be ignored.
REQ-028 stallRequest SHALL never be asserted in IDLE.
REQ-029 Counter width SHALL be $clog2(max(MUL_CYCLES,DIV_CYCLES)+1); no wrap-around is permitted.

Reset
REQ-030 Reset SHALL set hi = 0, lo = 0, busy = 0, counter = 0, state IDLE; readResult and stallRequest follow from these.
REQ-031 Reset asserted during BUSY SHALL abort the operation; the pending result SHALL never reach HI/LO.
REQ-032 start during a reset cycle SHALL be ignored.

Verification
REQ-033 MULT -3 x 7 (DATA_WIDTH 32, MUL_CYCLES 5) -> busy high 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-034 DIV -7 / 2 -> after 10 busy cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 7 / 0 -> lo = 0xFFFFFFFF, hi = 7.
REQ-035 MULTU 0xFFFFFFFF x 2 then MFLO on the cycle after issue -> stallRequest high for 5 cycles, then readResult = 0xFFFFFFFE with stallRequest low.
REQ-036 MTHI 0x1234 then MFHI next cycle -> readResult = 0x1234, lo unchanged, busy never high.
REQ-037 DIV issued, reset at 3rd busy cycle -> hi = lo = 0, busy = 0 at next edge, no later HI/LO update.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
